// File: rtl/dec_nto2n_scan_if.sv
// Select/decode bundle for dec_nto2n_scan.
// Master drives en/mode/sel; slave returns Y/idx/wrap.
interface dec_nto2n_scan_if #(
   parameter int N = 2
);
   localparam int W = 1 << N;

   logic         en;
   logic         mode;
   logic [N-1:0] sel;
   logic [W-1:0] Y;
   logic [N-1:0] idx;
   logic         wrap;

   modport master (
      output en, mode, sel,
      input  Y, idx, wrap
   );

   modport slave (
      input  en, mode, sel,
      output Y, idx, wrap
   );
endinterface

// File: rtl/dec_nto2n_scan.sv
// N-to-2^N one-hot decoder, direct or prescaled scan mode.
// Define DEC_ACTIVE_LOW_EN for active-low Y.
module dec_nto2n_scan #(
   parameter int N         = 2,
   parameter int PRESCALE  = 4,
   parameter int SCAN_LAST = 3
) (
   input  logic             clk,
   input  logic             rst,
   dec_nto2n_scan_if.slave  bus
);
   localparam int W  = 1 << N;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [N-1:0]  LAST = N'(SCAN_LAST);
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   if (N < 1) begin : g_bad_n
      $error("dec_nto2n_scan: N must be >= 1");
   end
   if (PRESCALE < 1) begin : g_bad_pre
      $error("dec_nto2n_scan: PRESCALE must be >= 1");
   end
   if (SCAN_LAST < 0 || SCAN_LAST > W - 1) begin : g_bad_last
      $error("dec_nto2n_scan: SCAN_LAST out of range");
   end

   logic [N-1:0]  idx_q, idx_d;
   logic [W-1:0]  yh_q, yh_d;
   logic          wrap_q, wrap_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          mode_q, mode_d;
   logic [PW-1:0] pre_eff;

   // Entering scan from direct always counts from a fresh prescaler.
   always_comb begin
      idx_d   = idx_q;
      pre_d   = pre_q;
      wrap_d  = 1'b0;
      mode_d  = mode_q;
      yh_d    = '0;
      pre_eff = mode_q ? pre_q : '0;
      if (bus.en) begin
         mode_d = bus.mode;
         if (!bus.mode) begin
            idx_d = bus.sel;
            pre_d = '0;
         end else if (pre_eff == PMAX) begin
            pre_d = '0;
            if (idx_q >= LAST) begin
               idx_d  = '0;
               wrap_d = 1'b1;
            end else begin
               idx_d = idx_q + N'(1);
            end
         end else begin
            pre_d = pre_eff + PW'(1);
         end
         yh_d = W'(1) << idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         yh_q   <= '0;
         wrap_q <= 1'b0;
         pre_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         yh_q   <= yh_d;
         wrap_q <= wrap_d;
         pre_q  <= pre_d;
         mode_q <= mode_d;
      end
   end

`ifdef DEC_ACTIVE_LOW_EN
   assign bus.Y = ~yh_q;
`else
   assign bus.Y = yh_q;
`endif
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;
endmodule
